// File: rtl/uart_pkg.sv
// Shared types and constants for the uart_rx receiver.
// Optional parity support is enabled with UART_RX_PARITY_EN.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } state_t;

  localparam int DATA_BITS      = 8;
  localparam int WORD_VALID_BIT = 15;

  function automatic int half_div(input int div);
    return div / 2;
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser; resets to 1 so an idle-high
// line does not look like a start edge.
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b1;
      q  <= 1'b1;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, mid-bit sampled, start-validated.
// Define UART_RX_PARITY_EN to add an even-parity bit and parity_err.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_DIV = 5208
) (
  input  logic        sysclk,
  input  logic        reset,
  input  logic        en,
  input  logic        serialIn,
  output logic [7:0]  data,
  output logic [15:0] word,
  output logic        valid,
  output logic        frame_err,
`ifdef UART_RX_PARITY_EN
  output logic        parity_err,
`endif
  output logic        busy
);

  localparam int HALF_DIV = half_div(CLK_DIV);
  localparam int CW       = $clog2(CLK_DIV);

  localparam logic [CW-1:0] LAST  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] HLAST = CW'(HALF_DIV - 1);

  if (CLK_DIV < 4) begin : g_div_chk
    $error("uart_rx: CLK_DIV must be at least 4");
  end

  state_t               state;
  logic [CW-1:0]        cnt;
  logic [2:0]           idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 rx_s;
`ifdef UART_RX_PARITY_EN
  logic                 par_bit;
`endif

  sync2 u_sync (
    .clk (sysclk),
    .rst (reset),
    .d   (serialIn),
    .q   (rx_s)
  );

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      shreg     <= '0;
      data      <= '0;
      word      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      valid     <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      if (!en) begin
        state <= IDLE;
        cnt   <= '0;
        idx   <= '0;
        busy  <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (!rx_s) begin
              state <= START;
              cnt   <= '0;
              busy  <= 1'b1;
            end
          end
          START: begin
            if (cnt == HLAST) begin
              cnt <= '0;
              idx <= '0;
              // line back high at mid-start: a glitch
              if (rx_s) begin
                state <= IDLE;
                busy  <= 1'b0;
              end else begin
                state <= DATA;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          DATA: begin
            if (cnt == LAST) begin
              cnt        <= '0;
              shreg[idx] <= rx_s;
              if (idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                state <= PARITY;
`else
                state <= STOP;
`endif
              end else begin
                idx <= idx + 1'b1;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
`ifdef UART_RX_PARITY_EN
          PARITY: begin
            if (cnt == LAST) begin
              cnt     <= '0;
              par_bit <= rx_s;
              state   <= STOP;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
`endif
          STOP: begin
            if (cnt == LAST) begin
              cnt  <= '0;
              data <= shreg;
              word <= {1'b1, 7'b0, shreg};
              if (rx_s) begin
                state <= IDLE;
                busy  <= 1'b0;
`ifdef UART_RX_PARITY_EN
                if (^{shreg, par_bit}) parity_err <= 1'b1;
                else                   valid      <= 1'b1;
`else
                valid <= 1'b1;
`endif
              end else begin
                frame_err <= 1'b1;
                state     <= BREAK;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          BREAK: begin
            if (rx_s) begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at CLK_DIV=16.
// Build with UART_RX_PARITY_EN to cover the parity frame.
module tb_uart_rx;

  localparam int D = 16;
`ifdef UART_RX_PARITY_EN
  localparam int LAT = 155 + D;
`else
  localparam int LAT = 155;
`endif

  logic        sysclk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b1;
  logic        serialIn = 1'b1;
  logic [7:0]  data;
  logic [15:0] word;
  logic        valid;
  logic        frame_err;
  logic        busy;
`ifdef UART_RX_PARITY_EN
  logic        parity_err;
  int          pcnt = 0;
`endif

  uart_rx #(.CLK_DIV(D)) dut (
    .sysclk    (sysclk),
    .reset     (reset),
    .en        (en),
    .serialIn  (serialIn),
    .data      (data),
    .word      (word),
    .valid     (valid),
    .frame_err (frame_err),
`ifdef UART_RX_PARITY_EN
    .parity_err(parity_err),
`endif
    .busy      (busy)
  );

  always #5 sysclk = ~sysclk;

  int cyc = 0;
  always @(posedge sysclk) cyc <= cyc + 1;

  int          n_assert = 0;
  int          n_fail = 0;
  logic [7:0]  vq_d[$];
  int          vq_c[$];
  logic [15:0] vword;
  logic        vbusy;
  int          fcnt = 0;
  int          dbl = 0;
  logic        prev_strobe = 1'b0;
  logic        bsy_seen = 1'b0;

  always @(negedge sysclk) begin
    if (valid) begin
      vq_d.push_back(data);
      vq_c.push_back(cyc);
      vword = word;
      vbusy = busy;
    end
    if (frame_err) fcnt++;
`ifdef UART_RX_PARITY_EN
    if (parity_err) pcnt++;
`endif
    if ((valid || frame_err) && prev_strobe) dbl++;
    prev_strobe = valid || frame_err;
    if (busy) bsy_seen = 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic hold(input int n);
    repeat (n) @(posedge sysclk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input logic p,
                      input logic stop, output int fall);
    serialIn = 1'b0;
    fall = cyc;
    hold(D);
    for (int i = 0; i < 8; i++) begin
      serialIn = b[i];
      hold(D);
    end
`ifdef UART_RX_PARITY_EN
    serialIn = p;
    hold(D);
`else
    if (p) serialIn = 1'b1;
`endif
    serialIn = stop;
    hold(D);
  endtask

  task automatic clear_mon();
    vq_d.delete();
    vq_c.delete();
    fcnt = 0;
    dbl = 0;
    bsy_seen = 1'b0;
  endtask

  int f0, f1;
  logic [7:0] b7e;

  initial begin
    hold(3);
    @(negedge sysclk);
    chk("rst_data", 32'(data), 32'h0);
    chk("rst_word", 32'(word), 32'h0);
    chk("rst_valid", 32'(valid), 32'h0);
    chk("rst_ferr", 32'(frame_err), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    reset = 1'b0;
    hold(5);

    // frame 0x41
    clear_mon();
    send(8'h41, 1'b0, 1'b1, f0);
    hold(4);
    chk("t1_count", 32'(vq_d.size()), 32'd1);
    chk("t1_lat", 32'(vq_c.size() > 0 ? vq_c[0] - f0 : -1), 32'(LAT));
    chk("t1_data", 32'(vq_d.size() > 0 ? vq_d[0] : 8'h0), 32'h41);
    chk("t1_word", 32'(vword), 32'h8041);
    chk("t1_busy", 32'(vbusy), 32'h0);
    chk("t1_ferr", 32'(fcnt), 32'd0);
    chk("t1_single", 32'(dbl), 32'd0);

    // start glitch
    clear_mon();
    serialIn = 1'b0;
    hold(4);
    serialIn = 1'b1;
    hold(20);
    chk("t2_busy_seen", 32'(bsy_seen), 32'h1);
    chk("t2_valid", 32'(vq_d.size()), 32'd0);
    chk("t2_ferr", 32'(fcnt), 32'd0);
    chk("t2_idle", 32'(busy), 32'h0);

    // framing error, line held low
    clear_mon();
    send(8'h55, 1'b0, 1'b0, f0);
    hold(40);
    chk("t3_ferr", 32'(fcnt), 32'd1);
    chk("t3_valid", 32'(vq_d.size()), 32'd0);
    chk("t3_data", 32'(data), 32'h55);
    chk("t3_busy_low", 32'(busy), 32'h1);
    serialIn = 1'b1;
    hold(6);
    chk("t3_busy_rel", 32'(busy), 32'h0);

    // back to back
    clear_mon();
    send(8'h48, 1'b0, 1'b1, f0);
    send(8'h69, 1'b0, 1'b1, f1);
    hold(4);
    chk("t4_count", 32'(vq_d.size()), 32'd2);
    chk("t4_data0", 32'(vq_d.size() > 0 ? vq_d[0] : 8'h0), 32'h48);
    chk("t4_data1", 32'(vq_d.size() > 1 ? vq_d[1] : 8'h0), 32'h69);
    chk("t4_gap", 32'(vq_c.size() > 1 ? vq_c[1] - vq_c[0] : -1),
        32'(D * (10 + (LAT - 155) / D)));
    chk("t4_ferr", 32'(fcnt), 32'd0);

    // reset during bit 4 of 0x7E
    clear_mon();
    b7e = 8'h7E;
    serialIn = 1'b0;
    hold(D);
    for (int i = 0; i < 4; i++) begin
      serialIn = b7e[i];
      hold(D);
    end
    serialIn = b7e[4];
    hold(8);
    reset = 1'b1;
    hold(2);
    chk("t5_data", 32'(data), 32'h0);
    chk("t5_word", 32'(word), 32'h0);
    chk("t5_valid", 32'(valid), 32'h0);
    chk("t5_ferr", 32'(frame_err), 32'h0);
    chk("t5_busy", 32'(busy), 32'h0);
    serialIn = 1'b1;
    reset = 1'b0;
    hold(5);
    clear_mon();
    send(8'h31, 1'b1, 1'b1, f0);
    hold(4);
    chk("t5_count", 32'(vq_d.size()), 32'd1);
    chk("t5_new", 32'(vq_d.size() > 0 ? vq_d[0] : 8'h0), 32'h31);

    // enable dropped mid-frame
    clear_mon();
    serialIn = 1'b0;
    hold(D);
    serialIn = 1'b1;
    hold(20);
    en = 1'b0;
    hold(1);
    chk("t6_busy", 32'(busy), 32'h0);
    hold(D * 10);
    chk("t6_strobes", 32'(vq_d.size() + fcnt), 32'd0);
    chk("t6_data", 32'(data), 32'h31);
    en = 1'b1;
    hold(4);

`ifdef UART_RX_PARITY_EN
    clear_mon();
    pcnt = 0;
    send(8'h41, 1'b0, 1'b1, f0);
    hold(4);
    chk("t7_good", 32'(vq_d.size()), 32'd1);
    chk("t7_perr0", 32'(pcnt), 32'd0);
    clear_mon();
    send(8'h41, 1'b1, 1'b1, f0);
    hold(4);
    chk("t7_perr", 32'(pcnt), 32'd1);
    chk("t7_novalid", 32'(vq_d.size()), 32'd0);
    chk("t7_data", 32'(data), 32'h41);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
